// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the sequential divider.
// - XLEN           : datapath width of the ALU and divider
// - ALU_FUNC_*     : 3-bit ALU function select; ADD also covers SUB through sub_sra
// - OP_*           : 2-bit divide opcode. Bit 0 set means unsigned. Bit 1 set means remainder.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_FUNC_ADD  = 3'b000;  // add, or sub when sub_sra=1
  localparam logic [2:0] ALU_FUNC_SLL  = 3'b001;
  localparam logic [2:0] ALU_FUNC_SLT  = 3'b010;
  localparam logic [2:0] ALU_FUNC_SLTU = 3'b011;
  localparam logic [2:0] ALU_FUNC_XOR  = 3'b100;
  localparam logic [2:0] ALU_FUNC_SR   = 3'b101;  // srl, or sra when sub_sra=1
  localparam logic [2:0] ALU_FUNC_OR   = 3'b110;
  localparam logic [2:0] ALU_FUNC_AND  = 3'b111;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

endpackage

// File: rtl/alu.sv
// 32-bit execute-stage ALU. This is the only adder available to the divider.
// Ports:
//   a, b     : operands
//   func     : ALU_FUNC_* select
//   sub_sra  : selects subtract for ADD and arithmetic shift for SR
//   s        : result
//   lu       : a < b unsigned. Valid for every func.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func,
  input  logic            sub_sra,
  output logic [XLEN-1:0] s,
  output logic            lu
);

  logic [XLEN-1:0]         sum;
  logic [$clog2(XLEN)-1:0] shamt;
  logic                    lt_s;

  assign sum   = sub_sra ? (a - b) : (a + b);
  assign shamt = b[$clog2(XLEN)-1:0];
  assign lu    = (a < b);
  assign lt_s  = ($signed(a) < $signed(b));

  always_comb begin
    s = '0;
    case (func)
      ALU_FUNC_ADD:  s = sum;
      ALU_FUNC_SLL:  s = a << shamt;
      ALU_FUNC_SLT:  s = XLEN'(lt_s);
      ALU_FUNC_SLTU: s = XLEN'(lu);
      ALU_FUNC_XOR:  s = a ^ b;
      ALU_FUNC_SR:   s = sub_sra ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      ALU_FUNC_OR:   s = a | b;
      ALU_FUNC_AND:  s = a & b;
      default:       s = '0;
    endcase
  end

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. It uses the shared ALU as
// its only arithmetic resource, does restoring division and produces one
// quotient bit per cycle.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : request pulse and opcode. Sampled only in IDLE.
//   dividend, divisor : rs1 / rs2. Captured when a start is accepted.
//   busy              : high from the cycle after accept through DONE
//   done              : one-cycle pulse. result is valid during it.
//   result            : quotient or remainder. Held until the next accept.
//   alu_a, alu_b,
//   alu_func,
//   alu_sub_sra       : ALU drive. Decoded from the current state.
//   alu_s, alu_lu     : ALU sum/difference and unsigned a<b flag
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; ALU driven 0/0
// NEG_A  | |dividend| into quo via 0 - dividend; rem cleared
// NEG_B  | |divisor| into dsr via 0 - divisor; cnt cleared
// ITER   | one restoring step per cycle, 32 cycles
// FIX    | pick quo/rem, negate through the ALU if the sign requires it
// DONE   | done pulse, then back to IDLE
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_func,
  output logic            alu_sub_sra,
  input  logic [XLEN-1:0] alu_s,
  input  logic            alu_lu
);

  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state;
  logic [1:0]      op_r;
  logic            sgn;
  logic [XLEN-1:0] dvd_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0] sh;
  logic            take;
  logic            is_rem;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] fix_v;
  logic            fix_neg;

  // The partial remainder shifted left is 33 bits wide. rem[31] is its top
  // bit. When that bit is set, the shifted value is at least dsr, so the
  // subtraction is taken no matter what the 32-bit compare reports.
  assign sh      = {rem[XLEN-2:0], quo[XLEN-1]};
  assign take    = rem[XLEN-1] | ~alu_lu;

  assign is_rem  = (op_r == OP_REM) || (op_r == OP_REMU);
  assign dvd_neg = sgn & dvd_r[XLEN-1];
  assign dvs_neg = sgn & dvs_r[XLEN-1];
  assign fix_v   = is_rem ? rem : quo;
  assign fix_neg = is_rem ? dvd_neg : (dvd_neg ^ dvs_neg);

  // The ALU operands are decoded from the registered state. This lets the
  // ALU result be consumed in the same cycle it is requested.
  assign alu_func = ALU_FUNC_ADD;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_sub_sra = 1'b0;
    case (state)
      S_NEG_A: begin
        alu_b       = dvd_r;
        alu_sub_sra = 1'b1;
      end
      S_NEG_B: begin
        alu_b       = dvs_r;
        alu_sub_sra = 1'b1;
      end
      S_ITER: begin
        alu_a       = sh;
        alu_b       = dsr;
        alu_sub_sra = 1'b1;
      end
      S_FIX: begin
        alu_b       = fix_v;
        alu_sub_sra = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_r   <= '0;
      sgn    <= 1'b0;
      dvd_r  <= '0;
      dvs_r  <= '0;
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            sgn   <= ~op[0];
            dvd_r <= dividend;
            dvs_r <= divisor;
            busy  <= 1'b1;
            if (divisor == '0) begin
              result <= ((op == OP_REM) || (op == OP_REMU)) ? dividend : '1;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_NEG_A;
            end
          end
        end
        S_NEG_A: begin
          quo   <= dvd_neg ? alu_s : dvd_r;
          rem   <= '0;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          dsr   <= dvs_neg ? alu_s : dvs_r;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          rem <= take ? alu_s : sh;
          quo <= {quo[XLEN-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITERS - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result <= fix_neg ? alu_s : fix_v;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed and random checks of alu_div_seq connected to the real ALU.
// Expected results are queued when an op is launched and popped when done pulses.
module tb_alu_div_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_s;
  logic [2:0]  alu_func;
  logic        alu_sub_sra, alu_lu;

  alu_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_sub_sra(alu_sub_sra),
    .alu_s(alu_s), .alu_lu(alu_lu)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .func(alu_func), .sub_sra(alu_sub_sra),
    .s(alu_s), .lu(alu_lu)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic is_rem;
    logic sgn;
    is_rem = o[1];
    sgn    = ~o[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
      return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Launches one op. If poke is set, a second start is driven in the fifth
  // busy cycle. The DUT must ignore it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit poke);
    exp_t e;
    exp_t got;
    int   acc;
    bit   seen;
    int   extra;
    e.res = exp;
    e.lat = (b == 32'd0) ? 1 : 36;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (poke && k == 4) begin
        start = 1'b1; op = OP_DIVU; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        got = sb.pop_front();
        chk(got.tag, result, got.res);
        chk({got.tag, "_lat"}, 32'(cyc - acc + 1), 32'(got.lat));
      end
    end
    start = 1'b0;
    if (!seen) begin
      got = sb.pop_front();
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout observed=no_done expected=done", got.tag);
    end
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    if (poke) begin
      extra = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "_single_done"}, 32'(extra), 32'd0);
      chk({tag, "_held"}, result, exp);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_alu_sub", 32'(alu_sub_sra), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 1'b0);
    run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_res(ro, ra, rb), 1'b0);
    end

    run_op("busy_start", OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 1'b1);

    // Reset asserted in the middle of ITER: everything returns to idle at once.
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("iter_busy", 32'(busy), 32'd1);
    chk("iter_sub", 32'(alu_sub_sra), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_alu_sub", 32'(alu_sub_sra), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'h0000_0003, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
